// File: rtl/clkdiv_pkg.sv
// Shared constants and elaboration-time helpers for the clkdiv integer clock divider.
package clkdiv_pkg;

  localparam int CLKDIV_MIN_RATIO = 2;

  // Returns 0 for a non-positive F1 so that the caller's range check rejects it.
  function automatic int clkdiv_ratio(input int f0, input int f1);
    if (f1 <= 0) return 0;
    return f0 / f1;
  endfunction

  function automatic int clkdiv_cnt_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/clkdiv_counter.sv
// Modulo-N counter with asynchronous active-low reset, wrap strobe and half-point strobe.
module clkdiv_counter
  import clkdiv_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clkdiv_cnt_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         half_pt
);

  localparam int HALF = N / 2;
  localparam logic [W-1:0] LAST     = W'(N - 1);
  localparam logic [W-1:0] HALF_PRE = W'(HALF - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign wrap    = (cnt == LAST);
  assign half_pt = (cnt == HALF_PRE);

endmodule

// File: rtl/clkdiv.sv
// Integer clock divider: out has period F0/F1 clk cycles, high for floor(N/2) cycles.
// Define CLKDIV_ODD_DUTY50_EN to stretch the high phase by half a cycle for odd N (50% duty).
module clkdiv
  import clkdiv_pkg::*;
#(
  parameter int F0 = 50_000_000,
  parameter int F1 = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic out
);

  localparam int  N     = clkdiv_ratio(F0, F1);
  localparam int  HALF  = N / 2;
  localparam int  W     = clkdiv_cnt_w(N);
  localparam bit  N_ODD = (N % 2) == 1;
  localparam logic [W-1:0] FALL_AT = W'(2 * HALF - 1);

  if ((F1 <= 0) || ((F0 % ((F1 <= 0) ? 1 : F1)) != 0) || (N < CLKDIV_MIN_RATIO)) begin : g_bad_params
    $fatal(1, "clkdiv: F0=%0d F1=%0d must give an integer ratio F0/F1 >= %0d",
           F0, F1, CLKDIV_MIN_RATIO);
  end

  logic [W-1:0] cnt;
  logic         wrap;
  logic         half_pt;
  logic         fall_pt;
  logic         out_pos;

  clkdiv_counter #(
    .N(N),
    .W(W)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt    (cnt),
    .wrap   (wrap),
    .half_pt(half_pt)
  );

  // For odd N the high phase ends one count before the wrap, keeping it HALF cycles long.
  assign fall_pt = N_ODD ? (cnt == FALL_AT) : wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pos <= 1'b0;
    end else if (fall_pt) begin
      out_pos <= 1'b0;
    end else if (half_pt) begin
      out_pos <= 1'b1;
    end
  end

`ifdef CLKDIV_ODD_DUTY50_EN
  if (N_ODD) begin : g_odd_duty50
    logic out_neg;

    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_neg <= 1'b0;
      end else begin
        out_neg <= out_pos;
      end
    end

    assign out = out_pos | out_neg;
  end else begin : g_even
    assign out = out_pos;
  end
`else
  assign out = out_pos;
`endif

endmodule

// File: tb/tb_clkdiv.sv
// Scoreboard bench for clkdiv: N=4 (default), N=2 and N=3 instances checked on both clock phases.
`timescale 1ns/1ps
module tb_clkdiv;

`ifdef CLKDIV_ODD_DUTY50_EN
  localparam bit ODD50 = 1'b1;
`else
  localparam bit ODD50 = 1'b0;
`endif

  typedef struct {
    int   k;
    logic e4p, e4n, e2p, e2n, e3p, e3n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out4, out2, out3;

  int   n_checks = 0;
  int   n_fail = 0;
  int   k = 0;
  int   highs3 = 0;
  exp_t sb[$];
  exp_t e;

  clkdiv dut4 (.clk(clk), .rst_n(rst_n), .out(out4));
  clkdiv #(.F0(10), .F1(5))  dut2 (.clk(clk), .rst_n(rst_n), .out(out2));
  clkdiv #(.F0(30), .F1(10)) dut3 (.clk(clk), .rst_n(rst_n), .out(out3));

  always #1 clk = ~clk;

  // Ideal waveform: rises at edge HALF, then every N edges, and stays high HALF cycles.
  function automatic logic pos_model(input int n, input int kk);
    int h;
    h = n / 2;
    if (kk < h) return 1'b0;
    return ((kk - h) % n) < h;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic cycle(input bit running);
    exp_t x;
    if (running) k++;
    x.k   = k;
    x.e4p = pos_model(4, k);
    x.e4n = pos_model(4, k);
    x.e2p = pos_model(2, k);
    x.e2n = pos_model(2, k);
    x.e3n = pos_model(3, k);
    x.e3p = pos_model(3, k) | (ODD50 & pos_model(3, k - 1));
    sb.push_back(x);
    @(posedge clk);
    #0.5;
    e = sb.pop_front();
    check("n4_pos", out4, e.e4p);
    check("n2_pos", out2, e.e2p);
    check("n3_pos", out3, e.e3p);
    if (out3 === 1'b1) highs3++;
    @(negedge clk);
    #0.5;
    check("n4_neg", out4, e.e4n);
    check("n2_neg", out2, e.e2n);
    check("n3_neg", out3, e.e3n);
    if (out3 === 1'b1) highs3++;
    $display("cycle k=%0d rst_n=%b out4=%b out2=%b out3=%b", e.k, rst_n, out4, out2, out3);
  endtask

  initial begin
    #0.5;
    check("reset_n4", out4, 1'b0);
    check("reset_n2", out2, 1'b0);
    check("reset_n3", out3, 1'b0);
    repeat (3) cycle(1'b0);
    rst_n = 1'b1;

    // Two full N=3 periods from release: high 2 half-cycles each, or 3 with the odd-duty option.
    highs3 = 0;
    repeat (6) cycle(1'b1);
    check("n3_high_halves", highs3 == (ODD50 ? 6 : 4), 1'b1);
    repeat (6) cycle(1'b1);

    for (int i = 0; i < 8 && !pos_model(4, k); i++) cycle(1'b1);
    check("pre_reset_n4_high", out4, 1'b1);

    rst_n = 1'b0;
    #0.1;
    check("midreset_n4", out4, 1'b0);
    check("midreset_n2", out2, 1'b0);
    check("midreset_n3", out3, 1'b0);
    k = 0;
    repeat (2) cycle(1'b0);
    rst_n = 1'b1;
    repeat (12) cycle(1'b1);

    if (sb.size() != 0) check("scoreboard_drained", 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
